// File: rtl/timer_countdown_core_if.sv
// Control and count bus between the tick/control side and the countdown timer core.
// The master drives the tick, run and load controls; the slave returns counts and status.
interface timer_countdown_core_if;
    logic       tick;
    logic       StartStop;
    logic       load;
    logic [7:0] msb_loadval;
    logic [7:0] lsb_loadval;
    logic [7:0] MSBbinaryout;
    logic [7:0] LSBbinaryout;
    logic       running;
    logic       done;
    logic       expire;

    modport master (
        output tick, StartStop, load, msb_loadval, lsb_loadval,
        input  MSBbinaryout, LSBbinaryout, running, done, expire
    );

    modport slave (
        input  tick, StartStop, load, msb_loadval, lsb_loadval,
        output MSBbinaryout, LSBbinaryout, running, done, expire
    );
endinterface

// File: rtl/timer_countdown_core.sv
// Two-digit MSB:LSB countdown timer with load, pause/run control and a sticky expiry flag.
// The LSB wraps at LSB_MODULUS and borrows from the MSB; all outputs come straight from flops.
module timer_countdown_core #(
    parameter int LSB_MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timer_countdown_core_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    localparam logic [7:0] LSB_MAX = 8'(LSB_MODULUS - 1);

    state_e     state_q;
    logic [7:0] msb_q;
    logic [7:0] lsb_q;
    logic       running_q;
    logic       done_q;
    logic       expire_q;

    logic [7:0] lsb_load_d;
    logic [7:0] msb_dec_d;
    logic [7:0] lsb_dec_d;
    logic       dec_zero_d;
    logic       count_nz_d;

    // Out-of-range LSB load values clamp to the top of the LSB range.
    always_comb begin
        lsb_load_d = (bus.lsb_loadval > LSB_MAX) ? LSB_MAX : bus.lsb_loadval;
        msb_dec_d  = msb_q;
        lsb_dec_d  = lsb_q - 8'd1;
        if (lsb_q == 8'd0) begin
            lsb_dec_d = LSB_MAX;
            msb_dec_d = msb_q - 8'd1;
        end
        dec_zero_d = (msb_dec_d == 8'd0) && (lsb_dec_d == 8'd0);
        count_nz_d = (msb_q != 8'd0) || (lsb_q != 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            msb_q     <= 8'd0;
            lsb_q     <= 8'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        msb_q <= bus.msb_loadval;
                        lsb_q <= lsb_load_d;
                    end else if (bus.StartStop && count_nz_d) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Dropping StartStop wins over a coincident tick; load is ignored here.
                    if (!bus.StartStop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (bus.tick) begin
                        msb_q <= msb_dec_d;
                        lsb_q <= lsb_dec_d;
                        if (dec_zero_d) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            expire_q  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.load) begin
                        msb_q   <= bus.msb_loadval;
                        lsb_q   <= lsb_load_d;
                        state_q <= IDLE;
                    end else if (bus.StartStop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.load) begin
                        msb_q   <= bus.msb_loadval;
                        lsb_q   <= lsb_load_d;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MSBbinaryout = msb_q;
    assign bus.LSBbinaryout = lsb_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.expire       = expire_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Bench for timer_countdown_core: directed scenarios then random control traffic,
// compared every cycle against a model that tracks the count as a single total of LSB units.
module tb_timer_countdown_core;

    localparam int MOD = 60;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic rst_n;
    timer_countdown_core_if bus ();

    timer_countdown_core #(.LSB_MODULUS(MOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int m_total;
    int m_mode;
    bit m_done;
    bit m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_total = 0;
        m_mode  = M_IDLE;
        m_done  = 1'b0;
        m_exp   = 1'b0;
    endtask

    function automatic int captured(input int mv, input int lv);
        return mv * MOD + ((lv > MOD - 1) ? MOD - 1 : lv);
    endfunction

    task automatic model_step(input bit tk, input bit ss, input bit ld, input int mv, input int lv);
        m_exp = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (ld) m_total = captured(mv, lv);
                else if (ss && m_total != 0) m_mode = M_RUN;
            end
            M_RUN: begin
                if (!ss) m_mode = M_PAUSE;
                else if (tk) begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin
                        m_mode = M_DONE;
                        m_done = 1'b1;
                        m_exp  = 1'b1;
                    end
                end
            end
            M_PAUSE: begin
                if (ld) begin
                    m_total = captured(mv, lv);
                    m_mode  = M_IDLE;
                end else if (ss) m_mode = M_RUN;
            end
            default: begin
                if (ld) begin
                    m_total = captured(mv, lv);
                    m_done  = 1'b0;
                    m_mode  = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".msb"},     32'(bus.MSBbinaryout), 32'(m_total / MOD));
        check({ctx, ".lsb"},     32'(bus.LSBbinaryout), 32'(m_total % MOD));
        check({ctx, ".running"}, 32'(bus.running),      32'(m_mode == M_RUN));
        check({ctx, ".done"},    32'(bus.done),         32'(m_done));
        check({ctx, ".expire"},  32'(bus.expire),       32'(m_exp));
    endtask

    // One clock: apply inputs, let the DUT and model take the edge, then compare just after it.
    task automatic drive_cycle(input string ctx, input bit tk, input bit ss, input bit ld,
                               input int mv, input int lv);
        bus.tick        = tk;
        bus.StartStop   = ss;
        bus.load        = ld;
        bus.msb_loadval = 8'(mv);
        bus.lsb_loadval = 8'(lv);
        @(posedge clk);
        model_step(tk, ss, ld, mv, lv);
        #1;
        check_outputs(ctx);
    endtask

    int exp_pulses;

    initial begin
        rst_n           = 1'b0;
        bus.tick        = 1'b0;
        bus.StartStop   = 1'b0;
        bus.load        = 1'b0;
        bus.msb_loadval = 8'd0;
        bus.lsb_loadval = 8'd0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 01:02 counting down across the borrow
        drive_cycle("ld0102", 0, 0, 1, 1, 2);
        drive_cycle("run0102", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle("tick0102", 1, 1, 0, 0, 0);
        check("borrow.msb", 32'(bus.MSBbinaryout), 32'd0);
        check("borrow.lsb", 32'(bus.LSBbinaryout), 32'd59);

        // 00:02 to expiry, then ticks after DONE
        drive_cycle("pause", 0, 0, 0, 0, 0);
        drive_cycle("ld0002", 0, 0, 1, 0, 2);
        drive_cycle("idle", 0, 0, 0, 0, 0);
        drive_cycle("run0002", 0, 1, 0, 0, 0);
        drive_cycle("tick0002a", 1, 1, 0, 0, 0);
        drive_cycle("tick0002b", 1, 1, 0, 0, 0);
        check("expiry.expire", 32'(bus.expire), 32'd1);
        check("expiry.done",   32'(bus.done),   32'd1);
        drive_cycle("post_done", 1, 1, 0, 0, 0);
        check("expiry.expire_drop", 32'(bus.expire), 32'd0);
        for (int i = 0; i < 3; i++) drive_cycle("done_hold", 1, 1, 0, 0, 0);

        // reload from DONE
        drive_cycle("ld0200", 0, 0, 1, 2, 0);
        check("reload.msb",  32'(bus.MSBbinaryout), 32'd2);
        check("reload.done", 32'(bus.done),         32'd0);

        // pause coincident with tick
        drive_cycle("ld0005", 0, 0, 1, 0, 5);
        drive_cycle("run0005", 0, 1, 0, 0, 0);
        drive_cycle("stop_tick", 1, 0, 0, 0, 0);
        check("pause.lsb", 32'(bus.LSBbinaryout), 32'd5);
        drive_cycle("resume", 0, 1, 0, 0, 0);
        drive_cycle("tick0005", 1, 1, 0, 0, 0);
        check("resume.lsb", 32'(bus.LSBbinaryout), 32'd4);

        // load ignored while running
        drive_cycle("ld_in_run", 1, 1, 1, 9, 9);
        drive_cycle("ld_in_run2", 1, 1, 0, 0, 0);

        // clamp and zero-start from IDLE
        drive_cycle("pause2", 0, 0, 0, 0, 0);
        drive_cycle("ld_clamp", 0, 0, 1, 0, 75);
        check("clamp.lsb", 32'(bus.LSBbinaryout), 32'd59);
        drive_cycle("ld0000", 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle("zero_start", 1, 1, 0, 0, 0);

        // asynchronous reset mid-count at 03:17
        drive_cycle("ld0317", 0, 0, 1, 3, 17);
        drive_cycle("run0317", 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1;
        rst_n = 1'b1;
        drive_cycle("post_rst", 1, 1, 0, 0, 0);

        // random traffic
        exp_pulses = 0;
        for (int i = 0; i < 800; i++) begin
            bit tk;
            bit ss;
            bit ld;
            tk = ($urandom_range(0, 1) == 1);
            ss = ($urandom_range(0, 99) < 85);
            ld = ($urandom_range(0, 99) < 6);
            drive_cycle("rand", tk, ss, ld, $urandom_range(0, 1), $urandom_range(0, 80));
            if (m_exp) exp_pulses++;
        end
        if (exp_pulses == 0) $display("note: random phase reached no expiry");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
